// File: rtl/button_press_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : button_press_classifier
//  Purpose  : Front-end for the three-button control panel. Each raw
//             pushbutton is synchronised, debounced and classified by how
//             long it was held. The result is a one-cycle long-press
//             (lung_n) or short-press (scurt_n) pulse per button.
//  Ports    : clock            - system clock, all logic on posedge
//             reset            - synchronous, active-high
//             b1, b2, b3       - raw asynchronous pushbuttons, active-high
//             lung_1..lung_3   - one-cycle pulse, long press on button n
//             scurt_1..scurt_3 - one-cycle pulse, short press released
//  Params   : DEBOUNCE_CYCLES  - stable cycles before debounced level moves
//             LONG_CYCLES      - debounced-high cycles that make a long press
//  Revision : 1.0 - initial release
// ============================================================================
module button_press_classifier #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int LONG_CYCLES     = 50000000
) (
   input  logic clock,
   input  logic reset,
   input  logic b1,
   input  logic b2,
   input  logic b3,
   output logic lung_1,
   output logic lung_2,
   output logic lung_3,
   output logic scurt_1,
   output logic scurt_2,
   output logic scurt_3
);

   localparam int NUM_CH = 3;
   localparam int DCW    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HCW    = $clog2(LONG_CYCLES + 1);

   localparam logic [DCW-1:0] c_DCNT_LAST = DCW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HCW-1:0] c_HCNT_LAST = HCW'(LONG_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } state_t;

   logic [NUM_CH-1:0] w_raw;
   logic [NUM_CH-1:0] w_lung;
   logic [NUM_CH-1:0] w_scurt;

   assign w_raw = {b3, b2, b1};

   assign lung_1  = w_lung[0];
   assign lung_2  = w_lung[1];
   assign lung_3  = w_lung[2];
   assign scurt_1 = w_scurt[0];
   assign scurt_2 = w_scurt[1];
   assign scurt_3 = w_scurt[2];

   // Three identical, independent channels.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch

      logic           r_sync1;
      logic           r_sync2;
      logic           r_db;
      logic [DCW-1:0] r_dcnt;
      logic [HCW-1:0] r_hcnt;
      logic [HCW-1:0] w_hcnt_next;
      state_t         r_state;
      state_t         w_state_next;
      logic           w_db_toggle;
      logic           w_db_rise;
      logic           r_lung;
      logic           r_scurt;
      logic           w_lung_next;
      logic           w_scurt_next;

      // ---------------------------------------------------------------
      // Two-flop synchroniser for the asynchronous button level.
      // ---------------------------------------------------------------
      always_ff @(posedge clock) begin
         if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
         end else begin
            r_sync1 <= w_raw[g];
            r_sync2 <= r_sync1;
         end
      end

      // ---------------------------------------------------------------
      // Debouncer: the level must differ from r_db for DEBOUNCE_CYCLES
      // consecutive cycles. Any return to the r_db level clears the count.
      // ---------------------------------------------------------------
      assign w_db_toggle = (r_sync2 != r_db) && (r_dcnt == c_DCNT_LAST);
      // Rise strobe lets the classifier start on the same edge db rises,
      // so the hold count lines up with the cycles db is actually high.
      assign w_db_rise   = w_db_toggle && !r_db;

      always_ff @(posedge clock) begin
         if (reset) begin
            r_db   <= 1'b0;
            r_dcnt <= '0;
         end else if (r_sync2 == r_db) begin
            r_dcnt <= '0;
         end else if (w_db_toggle) begin
            r_db   <= ~r_db;
            r_dcnt <= '0;
         end else begin
            r_dcnt <= r_dcnt + 1'b1;
         end
      end

      // ---------------------------------------------------------------
      // Press classifier: state register.
      // ---------------------------------------------------------------
      always_ff @(posedge clock) begin
         if (reset) begin
            r_state <= ST_IDLE;
            r_hcnt  <= '0;
            r_lung  <= 1'b0;
            r_scurt <= 1'b0;
         end else begin
            r_state <= w_state_next;
            r_hcnt  <= w_hcnt_next;
            r_lung  <= w_lung_next;
            r_scurt <= w_scurt_next;
         end
      end

      // ---------------------------------------------------------------
      // Press classifier: next state and pulse decode.
      // ---------------------------------------------------------------
      always_comb begin
         w_state_next = r_state;
         w_hcnt_next  = r_hcnt;
         w_lung_next  = 1'b0;
         w_scurt_next = 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_db_rise) begin
                  w_state_next = ST_PRESSED;
                  w_hcnt_next  = '0;
               end
            end

            ST_PRESSED: begin
               // Release is checked first so a release on the very cycle
               // the count reaches its limit is still a short press.
               if (!r_db) begin
                  w_scurt_next = 1'b1;
                  w_state_next = ST_IDLE;
               end else if (r_hcnt == c_HCNT_LAST) begin
                  w_lung_next  = 1'b1;
                  w_state_next = ST_HELD;
               end else begin
                  w_hcnt_next  = r_hcnt + 1'b1;
               end
            end

            ST_HELD: begin
               // Long press already reported; no repeat, no release pulse.
               if (!r_db) begin
                  w_state_next = ST_IDLE;
               end
            end

            default: begin
               w_state_next = ST_IDLE;
            end
         endcase
      end

      assign w_lung[g]  = r_lung;
      assign w_scurt[g] = r_scurt;

   end : g_ch

endmodule : button_press_classifier
`default_nettype wire
